// File: rtl/qc_pkg.sv
// Shared types for the quantum-state stream controller: complex sample type,
// FSM state encodings and host command codes.
package qc_pkg;

  localparam int QC_W = 8;

  typedef struct packed {
    logic signed [QC_W-1:0] re;
    logic signed [QC_W-1:0] im;
  } complex_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_STATE = 3'd1,
    ST_LOAD_GATE  = 3'd2,
    ST_APPLY      = 3'd3,
    ST_SEND       = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_LOAD_STATE = 2'b00,
    CMD_LOAD_GATE  = 2'b01,
    CMD_SEND       = 2'b10,
    CMD_CLEAR      = 2'b11
  } cmd_e;

endpackage

// File: rtl/qc_stream_controller_if.sv
// Host-side word streams: command/component input and result output,
// both with valid/ready handshakes.
interface qc_stream_controller_if #(parameter int W = 8);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/qc_stream_controller_mac.sv
// Complex multiply-accumulate for one gate row: acc += g * s, with the
// scaled and saturated view of the running sum available combinationally.
module complex_mac
  import qc_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 2,
  parameter int FRAC = W - 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                last,
  input  logic signed [W-1:0] g_re,
  input  logic signed [W-1:0] g_im,
  input  logic signed [W-1:0] s_re,
  input  logic signed [W-1:0] s_im,
  output logic signed [W-1:0] res_re,
  output logic signed [W-1:0] res_im,
  output logic                res_sat
);

  localparam int AW = 2 * W + N + 1;
  localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);

  // Fixed-point rescale: arithmetic shift truncates toward minus infinity.
  function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] v);
    return v >>> FRAC;
  endfunction

  function automatic logic signed [W-1:0] clamp(input logic signed [AW-1:0] v);
    if (v > MAXV)      return MAXV[W-1:0];
    else if (v < MINV) return MINV[W-1:0];
    else               return v[W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [AW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  logic signed [2*W-1:0] p_rr_p0, p_ii_p0, p_ri_p0, p_ir_p0;
  logic signed [AW-1:0]  sum_re_p0, sum_im_p0, sh_re_p0, sh_im_p0;
  logic signed [AW-1:0]  acc_re_p1, acc_im_p1;

  // Stage p0: products and running sum including this cycle's term
  always_comb begin
    p_rr_p0   = g_re * s_re;
    p_ii_p0   = g_im * s_im;
    p_ri_p0   = g_re * s_im;
    p_ir_p0   = g_im * s_re;
    sum_re_p0 = acc_re_p1 + AW'(p_rr_p0) - AW'(p_ii_p0);
    sum_im_p0 = acc_im_p1 + AW'(p_ri_p0) + AW'(p_ir_p0);
    sh_re_p0  = scale(sum_re_p0);
    sh_im_p0  = scale(sum_im_p0);
    res_re    = clamp(sh_re_p0);
    res_im    = clamp(sh_im_p0);
    res_sat   = clipped(sh_re_p0) || clipped(sh_im_p0);
  end

  // Stage p1: accumulator, restarted after the last column of each row
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_re_p1 <= '0;
      acc_im_p1 <= '0;
    end else if (en) begin
      acc_re_p1 <= last ? '0 : sum_re_p0;
      acc_im_p1 <= last ? '0 : sum_im_p0;
    end
  end

endmodule

// File: rtl/qc_stream_controller.sv
// Streaming quantum-state controller: loads an N-qubit state vector and
// DIM x DIM gate matrices from a host word stream, applies gates by serial
// complex MAC, and streams the state back on request.
module qc_stream_controller
  import qc_pkg::*;
#(
  parameter int N    = 2,
  parameter int W    = 8,
  parameter int FRAC = W - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  qc_stream_controller_if.slave bus,
  output logic                  busy,
  output logic [2:0]            phase,
  output logic [7:0]            gate_count,
  output logic                  sat
);

  localparam int DIM = 1 << N;
  localparam int GN  = DIM * DIM;
  localparam int CW  = 2 * N + 2;
  localparam logic [CW-1:0] STATE_LAST = CW'(2 * DIM - 1);
  localparam logic [CW-1:0] GATE_LAST  = CW'(2 * GN - 1);
  localparam logic [CW-1:0] APPLY_LAST = CW'(GN);
  localparam logic signed [W-1:0] ONE  = W'(1 << FRAC);

  state_e state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic signed [W-1:0] s_re [DIM];
  logic signed [W-1:0] s_im [DIM];
  logic signed [W-1:0] g_re [GN];
  logic signed [W-1:0] g_im [GN];
  logic signed [W-1:0] x_re [DIM];
  logic signed [W-1:0] x_im [DIM];

  logic in_ready, in_fire, out_valid;
  logic [W-1:0] out_data;
  logic do_clear, state_done, apply_done, mac_en, mac_last;
  logic [N-1:0] mac_row, mac_col;
  logic signed [W-1:0] res_re, res_im;
  logic res_sat;

  assign mac_row       = cnt[2*N-1:N];
  assign mac_col       = cnt[N-1:0];
  assign in_fire       = in_ready && bus.in_valid;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign phase         = state;

  // FSM state and word/step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state, handshake outputs and datapath strobes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = 1'b0;
    do_clear   = 1'b0;
    state_done = 1'b0;
    apply_done = 1'b0;
    mac_en     = 1'b0;
    mac_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          cnt_next = '0;
          case (cmd_e'(bus.in_data[1:0]))
            CMD_LOAD_STATE: state_next = ST_LOAD_STATE;
            CMD_LOAD_GATE:  state_next = ST_LOAD_GATE;
            CMD_SEND:       state_next = ST_SEND;
            default:        do_clear   = 1'b1;
          endcase
        end
      end
      ST_LOAD_STATE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (cnt == STATE_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            state_done = 1'b1;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      ST_LOAD_GATE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (cnt == GATE_LAST) begin
            state_next = ST_APPLY;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      ST_APPLY: begin
        busy = 1'b1;
        if (cnt == APPLY_LAST) begin
          apply_done = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          mac_en   = 1'b1;
          mac_last = (mac_col == N'(DIM - 1));
          cnt_next = cnt + CW'(1);
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = cnt[0] ? s_im[cnt[N:1]] : s_re[cnt[N:1]];
        if (bus.out_ready) begin
          if (cnt == STATE_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, gate and next-state storage plus status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIM; i++) begin
        s_re[i] <= (i == 0) ? ONE : '0;
        s_im[i] <= '0;
        x_re[i] <= '0;
        x_im[i] <= '0;
      end
      for (int i = 0; i < GN; i++) begin
        g_re[i] <= '0;
        g_im[i] <= '0;
      end
      gate_count <= '0;
      sat        <= 1'b0;
    end else begin
      if (do_clear) begin
        for (int i = 0; i < DIM; i++) begin
          s_re[i] <= (i == 0) ? ONE : '0;
          s_im[i] <= '0;
        end
        gate_count <= '0;
        sat        <= 1'b0;
      end
      if (state == ST_LOAD_STATE && in_fire) begin
        if (cnt[0]) s_im[cnt[N:1]] <= bus.in_data;
        else        s_re[cnt[N:1]] <= bus.in_data;
      end
      if (state_done) begin
        gate_count <= '0;
        sat        <= 1'b0;
      end
      if (state == ST_LOAD_GATE && in_fire) begin
        if (cnt[0]) g_im[cnt[2*N:1]] <= bus.in_data;
        else        g_re[cnt[2*N:1]] <= bus.in_data;
      end
      if (mac_en && mac_last) begin
        x_re[mac_row] <= res_re;
        x_im[mac_row] <= res_im;
        if (res_sat) sat <= 1'b1;
      end
      if (apply_done) begin
        for (int i = 0; i < DIM; i++) begin
          s_re[i] <= x_re[i];
          s_im[i] <= x_im[i];
        end
        gate_count <= gate_count + 8'd1;
      end
    end
  end

  complex_mac #(.W(W), .N(N), .FRAC(FRAC)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .en      (mac_en),
    .last    (mac_last),
    .g_re    (g_re[cnt[2*N-1:0]]),
    .g_im    (g_im[cnt[2*N-1:0]]),
    .s_re    (s_re[mac_col]),
    .s_im    (s_im[mac_col]),
    .res_re  (res_re),
    .res_im  (res_im),
    .res_sat (res_sat)
  );

endmodule

// File: tb/tb_qc_stream_controller.sv
// Self-checking bench for qc_stream_controller (N=2, W=8, FRAC=6) with a
// reference state-vector model feeding an output scoreboard.
module tb_qc_stream_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [2:0] phase;
  logic [7:0] gate_count;
  logic       sat;

  qc_stream_controller_if #(.W(8)) bus ();

  qc_stream_controller #(.N(2), .W(8), .FRAC(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .phase      (phase),
    .gate_count (gate_count),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  int ms_re[4], ms_im[4];
  int mg_re[16], mg_im[16];
  int mgc = 0;
  int msat = 0;
  int busy_cnt = 0;

  bit       pat_en = 1'b0;
  bit [5:0] pat = 6'b101001;
  int       pidx = 0;

  bit         stalled = 1'b0;
  logic [7:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // out_ready driver: always ready, or the 1,0,0,1,0,1 stall pattern
  always @(posedge clk) begin
    #1;
    if (pat_en) begin
      bus.out_ready = pat[pidx];
      pidx = (pidx + 1) % 6;
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  // Output monitor: scoreboard pops, stall stability, idle-zero and busy count
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (!bus.out_valid) chk("out_data_idle_zero", bus.out_data, 0);
      if (stalled && bus.out_valid) chk("stall_hold", bus.out_data, held);
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", exp_q.size(), 1);
        else chk("out_word", bus.out_data, exp_q.pop_front());
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic put(input logic [7:0] w);
    int b = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    if (!bus.in_ready) chk("put_timeout", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    while ((phase != 3'd0 || exp_q.size() != 0) && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 300) chk("wait_timeout", b, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ms_re[i] = (i == 0) ? 64 : 0;
      ms_im[i] = 0;
    end
    mgc  = 0;
    msat = 0;
  endtask

  function automatic int sat8(input int v, inout int flag);
    if (v > 127)  begin flag = 1; return 127;  end
    if (v < -128) begin flag = 1; return -128; end
    return v;
  endfunction

  task automatic model_apply();
    int nr[4], ni[4];
    for (int r = 0; r < 4; r++) begin
      int are = 0, aim = 0;
      for (int c = 0; c < 4; c++) begin
        are += mg_re[r*4+c] * ms_re[c] - mg_im[r*4+c] * ms_im[c];
        aim += mg_re[r*4+c] * ms_im[c] + mg_im[r*4+c] * ms_re[c];
      end
      nr[r] = sat8(are >>> 6, msat);
      ni[r] = sat8(aim >>> 6, msat);
    end
    for (int i = 0; i < 4; i++) begin
      ms_re[i] = nr[i];
      ms_im[i] = ni[i];
    end
    mgc = (mgc + 1) % 256;
  endtask

  task automatic send_state();
    put(8'h00);
    for (int i = 0; i < 4; i++) begin
      put(8'(ms_re[i]));
      put(8'(ms_im[i]));
    end
    mgc  = 0;
    msat = 0;
    chk("load_state_phase", phase, 0);
    chk("load_state_gc", gate_count, mgc);
    chk("load_state_sat", sat, msat);
  endtask

  task automatic send_gate(input bit junk);
    int b = 0;
    busy_cnt = 0;
    put(8'h01);
    for (int i = 0; i < 16; i++) begin
      put(8'(mg_re[i]));
      put(8'(mg_im[i]));
    end
    if (junk) begin
      bus.in_data  = 8'hFE;
      bus.in_valid = 1'b1;
    end
    while (phase != 3'd0 && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    bus.in_valid = 1'b0;
    if (b >= 100) chk("apply_timeout", b, 0);
    model_apply();
    chk("apply_phase", phase, 0);
    chk("busy_cycles", busy_cnt, 17);
    chk("gate_count", gate_count, mgc);
    chk("sat", sat, msat);
  endtask

  task automatic request_send();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(ms_re[i]));
      exp_q.push_back(8'(ms_im[i]));
    end
    put(8'h02);
    wait_done();
    chk("send_done_phase", phase, 0);
  endtask

  task automatic swap01_gate();
    for (int i = 0; i < 16; i++) begin
      mg_re[i] = 0;
      mg_im[i] = 0;
    end
    mg_re[0*4+1] = 64;
    mg_re[1*4+0] = 64;
    mg_re[2*4+2] = 64;
    mg_re[3*4+3] = 64;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_phase", phase, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gate_count", gate_count, 0);
    chk("rst_sat", sat, 0);

    // Send after reset returns |0>
    request_send();

    // Swap of indices 0 and 1 on |0>
    ms_re = '{64, 0, 0, 0};
    ms_im = '{0, 0, 0, 0};
    send_state();
    swap01_gate();
    send_gate(1'b0);
    chk("swap_gc_one", gate_count, 1);
    request_send();

    // All-0x40 gate on all-0x40 state saturates; stalled readout
    ms_re = '{64, 64, 64, 64};
    ms_im = '{0, 0, 0, 0};
    send_state();
    for (int i = 0; i < 16; i++) begin
      mg_re[i] = 64;
      mg_im[i] = 0;
    end
    send_gate(1'b0);
    chk("sat_set", sat, 1);
    pat_en = 1'b1;
    pidx   = 0;
    request_send();
    pat_en = 1'b0;

    // Clear command
    put(8'h03);
    model_reset();
    chk("clear_sat", sat, 0);
    chk("clear_gc", gate_count, 0);
    chk("clear_phase", phase, 0);
    request_send();

    // Random state, two chained random gates, stalled readout
    for (int i = 0; i < 4; i++) begin
      ms_re[i] = $signed(8'($urandom_range(0, 255)));
      ms_im[i] = $signed(8'($urandom_range(0, 255)));
    end
    send_state();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mg_re[i] = $signed(8'($urandom_range(0, 255)));
        mg_im[i] = $signed(8'($urandom_range(0, 255)));
      end
      send_gate(1'b0);
    end
    chk("chain_gc", gate_count, 2);
    pat_en = 1'b1;
    pidx   = 0;
    request_send();
    pat_en = 1'b0;

    // Reset in the middle of a gate load
    put(8'h01);
    for (int i = 0; i < 5; i++) put(8'h11);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("midrst_phase", phase, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_gc", gate_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    request_send();

    // Junk held on the input during APPLY is ignored
    ms_re = '{10, -20, 30, -40};
    ms_im = '{5, 6, -7, 8};
    send_state();
    swap01_gate();
    send_gate(1'b1);
    chk("junk_phase", phase, 0);
    request_send();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
